// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: aligns and issues one bus access per instruction, holding the pipeline until done.
// Optional LSU_TIMEOUT_EN adds a 255-cycle bus timeout that reports BusErr_M.
module mem_stage_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ALUResult_M,
   input  logic [31:0] WriteData_M,
   input  logic        MemWrite_M,
   input  logic [1:0]  ResultSrc_M,
   input  logic [2:0]  Funct3_M,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ReadData_M,
   output logic        Stall_M,
`ifdef LSU_TIMEOUT_EN
   output logic        BusErr_M,
`endif
   output logic        MisAlign_M
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   state_t      state;
   size_t       size;
   logic        access_valid, aligned;
   logic [31:0] wdata_lane, load_ext;
   logic [3:0]  be_lane;
   logic        ld_pend;
   logic [2:0]  ld_f3;
   logic [1:0]  ld_lo;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
`ifdef LSU_TIMEOUT_EN
   logic [7:0]  tmo_cnt;
`endif

   assign access_valid = MemWrite_M | (ResultSrc_M == 2'b01);

   // Stores only define b/h/w; loads add bu/hu. Everything else is a word.
   always_comb begin
      size = SZ_W;
      case (Funct3_M)
         3'b000:  size = SZ_B;
         3'b001:  size = SZ_H;
         3'b100:  size = MemWrite_M ? SZ_W : SZ_B;
         3'b101:  size = MemWrite_M ? SZ_W : SZ_H;
         default: size = SZ_W;
      endcase
   end

   always_comb begin
      aligned    = 1'b1;
      wdata_lane = WriteData_M;
      be_lane    = 4'b1111;
      case (size)
         SZ_B: begin
            wdata_lane = {4{WriteData_M[7:0]}};
            be_lane    = 4'b0001 << ALUResult_M[1:0];
         end
         SZ_H: begin
            aligned    = ~ALUResult_M[0];
            wdata_lane = {2{WriteData_M[15:0]}};
            be_lane    = 4'b0011 << ALUResult_M[1:0];
         end
         default: aligned = (ALUResult_M[1:0] == 2'b00);
      endcase
   end

   assign MisAlign_M = access_valid & ~aligned;
   assign Stall_M    = access_valid & aligned & (state != DONE);

   // Extraction uses the size/offset latched at issue, not the live inputs.
   always_comb begin
      ld_byte = 8'h00;
      case (ld_lo)
         2'd0: ld_byte = mem_rdata[7:0];
         2'd1: ld_byte = mem_rdata[15:8];
         2'd2: ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half  = ld_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_ext = mem_rdata;
      case (ld_f3)
         3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  load_ext = {24'h0, ld_byte};
         3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  load_ext = {16'h0, ld_half};
         default: load_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'h0;
         mem_wdata  <= 32'h0;
         mem_be     <= 4'h0;
         ReadData_M <= 32'h0;
         ld_pend    <= 1'b0;
         ld_f3      <= 3'b000;
         ld_lo      <= 2'b00;
`ifdef LSU_TIMEOUT_EN
         tmo_cnt    <= 8'h0;
         BusErr_M   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (access_valid && aligned) begin
               state     <= REQ;
               mem_req   <= 1'b1;
               mem_we    <= MemWrite_M;
               mem_addr  <= {ALUResult_M[31:2], 2'b00};
               mem_wdata <= wdata_lane;
               mem_be    <= be_lane;
               ld_pend   <= ~MemWrite_M;
               ld_f3     <= Funct3_M;
               ld_lo     <= ALUResult_M[1:0];
`ifdef LSU_TIMEOUT_EN
               tmo_cnt   <= 8'h0;
`endif
            end
            REQ: begin
               if (mem_ack) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  if (ld_pend) ReadData_M <= load_ext;
               end
`ifdef LSU_TIMEOUT_EN
               else if (tmo_cnt == 8'd254) begin
                  state    <= DONE;
                  mem_req  <= 1'b0;
                  BusErr_M <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
`endif
            end
            default: begin
               state <= IDLE;
`ifdef LSU_TIMEOUT_EN
               BusErr_M <= 1'b0;
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu; inputs change #1 after the rising edge and are sampled there.
module tb_mem_stage_lsu;
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] ALUResult_M = '0, WriteData_M = '0, mem_rdata = '0;
   logic        MemWrite_M = 1'b0, mem_ack = 1'b0;
   logic [1:0]  ResultSrc_M = 2'b00;
   logic [2:0]  Funct3_M = 3'b000;
   logic        mem_req, mem_we, Stall_M, MisAlign_M;
   logic [31:0] mem_addr, mem_wdata, ReadData_M;
   logic [3:0]  mem_be;
`ifdef LSU_TIMEOUT_EN
   logic        BusErr_M;
`endif
   int tests = 0, fails = 0;

   mem_stage_lsu dut (
      .clk(clk), .rst(rst), .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
      .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M), .Funct3_M(Funct3_M),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ReadData_M(ReadData_M),
      .Stall_M(Stall_M),
`ifdef LSU_TIMEOUT_EN
      .BusErr_M(BusErr_M),
`endif
      .MisAlign_M(MisAlign_M));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle_bus();
      MemWrite_M = 1'b0; ResultSrc_M = 2'b00; mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; #1;
      tests++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL rst_ctrl req=%b we=%b exp 0 0", mem_req, mem_we); end
      tests++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin fails++; $display("FAIL rst_bus addr=%h wdata=%h be=%b exp 0", mem_addr, mem_wdata, mem_be); end
      tests++; if (ReadData_M !== 32'h0 || Stall_M !== 1'b0 || MisAlign_M !== 1'b0) begin fails++; $display("FAIL rst_out rd=%h stall=%b mis=%b exp 0", ReadData_M, Stall_M, MisAlign_M); end
      tick(); tick(); rst = 1'b0; tick();
   endtask

   // Zero-wait load issued in the current IDLE cycle; leaves the FSM in IDLE afterwards.
   task automatic do_load(input string nm, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdata, input logic [31:0] exp);
      ALUResult_M = addr; Funct3_M = f3; ResultSrc_M = 2'b01; MemWrite_M = 1'b0; #1;
      tests++; if (Stall_M !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL %s_idle stall=%b req=%b exp 1 0", nm, Stall_M, mem_req); end
      tick();
      tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || Stall_M !== 1'b1 || mem_addr !== {addr[31:2], 2'b00}) begin
         fails++; $display("FAIL %s_req req=%b we=%b stall=%b addr=%h exp 1 0 1 %h", nm, mem_req, mem_we, Stall_M, mem_addr, {addr[31:2], 2'b00}); end
      mem_ack = 1'b1; mem_rdata = rdata;
      tick();
      mem_ack = 1'b0;
      tests++; if (mem_req !== 1'b0 || Stall_M !== 1'b0 || ReadData_M !== exp) begin
         fails++; $display("FAIL %s_done req=%b stall=%b rd=%h exp 0 0 %h", nm, mem_req, Stall_M, ReadData_M, exp); end
      tick();
      idle_bus();
   endtask

   task automatic test_lw();
      do_load("lw100", 32'h100, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF);
   endtask

   task automatic test_store();
      int stall_cnt;
      MemWrite_M = 1'b1; ResultSrc_M = 2'b00; Funct3_M = 3'b000; ALUResult_M = 32'h103; WriteData_M = 32'h0000_00A5;
      tick();
      tests++; if (mem_be !== 4'b1000 || mem_wdata !== 32'hA5A5A5A5 || mem_addr !== 32'h100 || mem_we !== 1'b1 || mem_req !== 1'b1) begin
         fails++; $display("FAIL sb_bus be=%b wd=%h addr=%h we=%b req=%b exp 1000 a5a5a5a5 100 1 1", mem_be, mem_wdata, mem_addr, mem_we, mem_req); end
      stall_cnt = 0;
      for (int i = 0; i < 3; i++) begin if (Stall_M === 1'b1 && mem_req === 1'b1) stall_cnt++; tick(); end
      tests++; if (stall_cnt !== 3) begin fails++; $display("FAIL sb_wait held=%0d exp 3", stall_cnt); end
      mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
      tick(); mem_ack = 1'b0;
      tests++; if (mem_req !== 1'b0 || ReadData_M !== 32'hDEADBEEF) begin fails++; $display("FAIL sb_done req=%b rd=%h exp 0 deadbeef", mem_req, ReadData_M); end
      tick();
      // sh at offset 2, back to back with the previous store
      Funct3_M = 3'b001; ALUResult_M = 32'h202; WriteData_M = 32'h1234_ABCD;
      tick();
      tests++; if (mem_be !== 4'b1100 || mem_wdata !== 32'hABCDABCD || mem_addr !== 32'h200) begin
         fails++; $display("FAIL sh_bus be=%b wd=%h addr=%h exp 1100 abcdabcd 200", mem_be, mem_wdata, mem_addr); end
      mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();
      // undefined funct3 store is a full word
      Funct3_M = 3'b011; ALUResult_M = 32'h308; WriteData_M = 32'hCAFE_F00D;
      tick();
      tests++; if (mem_be !== 4'b1111 || mem_wdata !== 32'hCAFEF00D || mem_addr !== 32'h308) begin
         fails++; $display("FAIL sx_bus be=%b wd=%h addr=%h exp 1111 cafef00d 308", mem_be, mem_wdata, mem_addr); end
      mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();
      idle_bus();
   endtask

   task automatic test_back_to_back();
      do_load("lh",  32'h102, 3'b001, 32'h8001_0000, 32'hFFFF8001);
      do_load("lhu", 32'h102, 3'b101, 32'h8001_0000, 32'h0000_8001);
      do_load("lb",  32'h101, 3'b000, 32'h0000_F000, 32'hFFFF_FFF0);
      do_load("lbu", 32'h103, 3'b100, 32'h7F00_0000, 32'h0000_007F);
      do_load("lx",  32'h104, 3'b111, 32'h8765_4321, 32'h8765_4321);
   endtask

   task automatic test_misalign();
      int req_seen;
      ALUResult_M = 32'h101; Funct3_M = 3'b010; ResultSrc_M = 2'b01; MemWrite_M = 1'b0; #1;
      tests++; if (MisAlign_M !== 1'b1 || Stall_M !== 1'b0) begin fails++; $display("FAIL mis_lw mis=%b stall=%b exp 1 0", MisAlign_M, Stall_M); end
      req_seen = 0;
      for (int i = 0; i < 4; i++) begin tick(); if (mem_req !== 1'b0) req_seen++; end
      tests++; if (req_seen !== 0 || ReadData_M !== 32'h8765_4321) begin fails++; $display("FAIL mis_noreq reqs=%0d rd=%h exp 0 87654321", req_seen, ReadData_M); end
      MemWrite_M = 1'b1; ResultSrc_M = 2'b00; Funct3_M = 3'b001; ALUResult_M = 32'h201; #1;
      tests++; if (MisAlign_M !== 1'b1 || Stall_M !== 1'b0) begin fails++; $display("FAIL mis_sh mis=%b stall=%b exp 1 0", MisAlign_M, Stall_M); end
      tick();
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL mis_sh_req req=%b exp 0", mem_req); end
      idle_bus(); #1;
      tests++; if (MisAlign_M !== 1'b0) begin fails++; $display("FAIL mis_clear mis=%b exp 0", MisAlign_M); end
      tick();
   endtask

   task automatic test_reset_inflight();
      ALUResult_M = 32'h400; Funct3_M = 3'b010; ResultSrc_M = 2'b01; MemWrite_M = 1'b0;
      tick();
      tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rsti_req req=%b exp 1", mem_req); end
      rst = 1'b1; #1;
      tests++; if (mem_req !== 1'b0 || ReadData_M !== 32'h0 || mem_addr !== 32'h0) begin
         fails++; $display("FAIL rsti_async req=%b rd=%h addr=%h exp 0 0 0", mem_req, ReadData_M, mem_addr); end
      idle_bus();
      tick(); rst = 1'b0;
      tick(); mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      tick(); mem_ack = 1'b0; tick();
      tests++; if (mem_req !== 1'b0 || ReadData_M !== 32'h0 || Stall_M !== 1'b0) begin
         fails++; $display("FAIL rsti_late_ack req=%b rd=%h stall=%b exp 0 0 0", mem_req, ReadData_M, Stall_M); end
      // first access after reset starts normally
      do_load("post_rst", 32'h500, 3'b010, 32'hA5A5_0001, 32'hA5A5_0001);
   endtask

`ifdef LSU_TIMEOUT_EN
   task automatic test_timeout();
      int cyc;
      logic got;
      ALUResult_M = 32'h600; Funct3_M = 3'b010; ResultSrc_M = 2'b01; MemWrite_M = 1'b0;
      tick();
      cyc = 0; got = 1'b0;
      while (!got && cyc < 400) begin
         if (BusErr_M === 1'b1) got = 1'b1; else begin cyc++; tick(); end
      end
      tests++; if (!got || cyc !== 255) begin fails++; $display("FAIL tmo_err got=%b cycles=%0d exp 1 255", got, cyc); end
      tests++; if (mem_req !== 1'b0 || Stall_M !== 1'b0 || ReadData_M !== 32'hA5A5_0001) begin
         fails++; $display("FAIL tmo_state req=%b stall=%b rd=%h exp 0 0 a5a50001", mem_req, Stall_M, ReadData_M); end
      tick();
      tests++; if (BusErr_M !== 1'b0) begin fails++; $display("FAIL tmo_pulse err=%b exp 0", BusErr_M); end
      idle_bus(); tick();
   endtask
`endif

   initial begin
      test_reset();
      test_lw();
      test_store();
      test_back_to_back();
      test_misalign();
      test_reset_inflight();
`ifdef LSU_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
